// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame constants.
package uart_pkg;
  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_e;
endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: parallel byte, valid/framing-error strobes and busy flag.
interface uart_rx_if #(parameter int W = 8);
  logic [W-1:0] data;
  logic         valid;
  logic         ferr;
  logic         busy;

  modport master (output data, valid, ferr, busy);
  modport slave  (input  data, valid, ferr, busy);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer; resets to 1 so an idle serial line/button reads as released.
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic meta_q, sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid/framing-error strobes.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int D         = 234,
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_ferr,
  output logic                 o_busy
);
  import uart_pkg::*;

  localparam int CW = $clog2(D);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF = CW'((D - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(D - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 rxd_s;

  uart_sync2 u_sync (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_rxd), .o_q(rxd_s));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        perr_d = 1'b0;
        if (rxd_s != IDLE_LEVEL) state_d = START;
      end
      START: begin
        // Half a bit in: a line back high here was only a glitch.
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = (rxd_s == IDLE_LEVEL) ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxd_s;
          bit_d          = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == BLAST) state_d = PARITY;
`else
          if (bit_q == BLAST) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          perr_d  = ^{shift_q, rxd_s};
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rxd_s == IDLE_LEVEL) begin
            state_d = IDLE;
            if (perr_q) ferr_d = 1'b1;
            else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
          end else begin
            // Stop bit low: hold off until the line is released.
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxd_s == IDLE_LEVEL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_ferr  = ferr_q;
  assign o_busy  = (state_q != IDLE);
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the 8N1 stream driven on o_txd by the UART transmit wrapper.
- Sits directly downstream of that wrapper: in loop-back on the board, or in the same bench.
- Recovers each character, presents it as a parallel byte with a one-cycle valid strobe, and flags framing errors.
- Its output drives the LED/count display logic that shows the received count.

Parameters:
- D, 234, clock cycles per bit. Must equal the transmitter's D. Minimum legal value is 3.
- DATA_BITS, 8, data bits per frame, sent LSB first. Only 8 is verified.

Ports:
- i_clk  input  1  system clock. All logic is clocked on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_rxd  input  1  serial line. Idle level is high. Asynchronous to i_clk.
- o_data  output  8  last correctly received byte.
- o_valid  output  1  one-cycle strobe: o_data has just been updated.
- o_ferr  output  1  one-cycle strobe: framing (or parity) error.
- o_busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - o_data=8'h00, o_valid=0, o_ferr=0, o_busy=0.
  - Synchronizer flops are reset to 1. State=IDLE, bit counter=0, clock counter=0.
- Synchronizer: i_rxd passes through two flops (rxd_s) before any use. This adds a fixed 2-cycle delay.
- Clock counter counts 0..D-1. Bit index counts 0..7.
- States:
  - IDLE:
    - When rxd_s==0, go to START with clock counter=0.
    - o_busy=1 from the next cycle.
  - START:
    - When clock counter==(D-1)/2 (integer division), sample rxd_s.
    - If rxd_s==1 the low was a glitch: go to IDLE with no strobe.
    - Otherwise reset the clock counter and go to DATA with bit index=0.
  - DATA:
    - When clock counter==D-1, sample rxd_s into shift[bit index] (LSB first) and reset the clock counter.
    - After bit index 7 is sampled, go to STOP.
  - STOP:
    - When clock counter==D-1, sample rxd_s.
    - If 1: o_data<=shift, o_valid=1 for one cycle, go to IDLE.
    - If 0: o_ferr=1 for one cycle, o_data is unchanged, go to BREAK.
  - BREAK:
    - Wait until rxd_s==1, then go to IDLE.
    - This prevents a held-low line from retriggering reception.
- Latency: o_valid asserts 2 + (D-1)/2 + 9*D + 1 clocks after the i_rxd falling edge. Bench tolerance is ±1 clock.
- Mutual exclusion: o_valid and o_ferr are never high in the same cycle.
- Back-to-back frames: the stop-bit sample occurs mid-bit, so IDLE is re-entered before the next start edge. A start bit that begins immediately after the stop bit must be received.
- Reset mid-frame: reception is aborted immediately, with no strobe. After release, the block waits in IDLE for the next falling edge.
- o_data holds its value indefinitely until the next valid frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state between DATA and STOP samples one extra bit, D clocks after the last data bit.
  - Even parity is expected.
  - On mismatch, the stop bit is still checked. The frame then ends with o_ferr=1 and o_data is unchanged.
  - Latency grows by D.
- Undefined: the frame is 8N1 as described above, and no PARITY state exists.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - DATA_BITS=8;
  - IDLE_LEVEL=1'b1.
  - The transmit side reuses this package.
- Sub-module uart_sync2: two-flop synchronizer with async active-low reset to 1. It is reused for button inputs.

Test Plan (D=5):
- Transmitter wrapper loop-back, 10 count presses then send -> exactly one o_valid pulse with o_data=8'h0A; o_ferr stays 0.
- Second frame with 8 presses -> o_data=8'h08, exactly one o_valid pulse; o_busy low between frames.
- 1-clock low glitch on i_rxd while idle -> no o_valid and no o_ferr; o_busy returns to 0 within (D-1)/2+3 clocks.
- Frame 8'h55 with stop bit forced to 0 and line held low 30 clocks -> one o_ferr pulse; o_data unchanged; no new frame until the line goes high.
- i_rst_n pulsed low mid-way through the DATA bits -> o_busy=0 and outputs at reset values immediately; the next full frame 8'hA5 is received correctly.
- With UART_RX_PARITY_EN defined: 8'h03 sent with parity bit 1 -> o_ferr pulse; the same byte with parity bit 0 -> o_valid with o_data=8'h03.
